fine_con_dsm_driver: RTL and testbench
======================================

// Module: fine_con_dsm_driver
// PURPOSE
// - Sits directly downstream of the fine frequency tracker in ref_clk domain; consumes its 13-bit fine control word.
// - Slews the applied code toward the target at a programmable rate (no large frequency steps on oscillator).
// - Splits code into 8-bit integer (oscillator cap bank) + 5-bit fraction, dithered by 1st-order delta-sigma.
// PARAMETERS
// - CODE_W  13  total fine-control width (integer + fraction)
// - FRAC_W  5   fractional LSBs handled by delta-sigma; INT_W = CODE_W-FRAC_W = 8
// - STEP_W  4   slew-step control width
// PORTS
// - ref_clk             in   1       sole clock; all state on rising edge
// - rst                 in   1       asynchronous, active-low reset
// - fftl_en             in   1       block enable; 0 -> hold all state, outputs frozen
// - fine_con_in         in   CODE_W  target code from tracker (osc_fine_con_final)
// - fine_con_valid      in   1       1-cycle strobe: fine_con_in is new target
// - manual_mode         in   1       1 -> target = manual_control_osc, sampled every cycle
// - manual_control_osc  in   CODE_W  manual target code
// - slew_step           in   STEP_W  max |change| of applied code per cycle; 0 = jump immediately
// - dsm_en              in   1       1 -> delta-sigma dither on; 0 -> round-to-nearest
// - osc_code            out  INT_W   registered integer code to oscillator bank
// - applied_code        out  CODE_W  current slewed code (pre-dither), for observation
// - settled             out  1       applied_code == target and FSM in HOLD
// BEHAVIOUR
// - Reset (rst=0): target=0, applied_code=0, dsm_acc=0, osc_code=0, settled=0, FSM=IDLE.
// - Target reg: manual_mode=1 -> loads manual_control_osc each cycle, fine_con_valid ignored;
//   manual_mode=0 -> loads fine_con_in only when fine_con_valid=1. Mode switch needs no reset; slew continues.
// - FSM (advances only when fftl_en=1):
//   IDLE -> SLEW on first cycle with fftl_en=1.
//   SLEW: diff = target - applied_code (signed, CODE_W+1 bits).
//     slew_step=0 -> applied_code = target (1 cycle).
//     else applied_code += sign(diff)*min(slew_step,|diff|); never overshoots.
//     diff==0 after update -> HOLD.
//   HOLD: settled=1; target change (new valid or manual value differs) -> SLEW, settled=0 same cycle.
//   New target during SLEW retargets immediately; no restart penalty.
// - Target update and slew step coincide: step computed from the OLD target; new target used next cycle.
// - Dither (per cycle, fftl_en=1): int = applied_code[CODE_W-1:FRAC_W], frac = applied_code[FRAC_W-1:0].
//   dsm_en=1: {carry,dsm_acc} = dsm_acc + frac; osc_code = int + carry.
//   dsm_en=0: dsm_acc cleared to 0; osc_code = int + frac[FRAC_W-1].
//   Saturate: int=255 with +1 -> osc_code=255 (never wraps to 0).
// - Latency: applied_code -> osc_code is 1 ref_clk; fine_con_valid -> first applied_code move is 2 ref_clk.
// - fftl_en=0: all registers hold; re-enable resumes from held state, no glitch on osc_code.
// - Average of osc_code over 32 cycles with dsm_en=1 equals applied_code/32 exactly when no saturation.
// STRUCTURE
// - Shared package (fine_track_pkg): CODE_W/FRAC_W/STEP_W constants; typedef enum {IDLE,SLEW,HOLD} fcd_state_t.
// - One sub-module: fcd_dsm1 (1st-order accumulator + carry + saturating add, FRAC_W/INT_W params).
// - Slew FSM and target register stay in top module.
// TESTING
// - Reset: rst=0 mid-SLEW -> all outputs 0 within same cycle (async), FSM IDLE; rst release -> no spurious move.
// - Slew: target 0->1000, slew_step=15 -> applied_code +15/cycle, 67th step lands exactly 1000, settled=1, no overshoot.
// - Jump: slew_step=0, valid with 4000 -> applied_code=4000 two cycles after valid; settled next cycle.
// - Dither: applied_code=8'd100<<5 | 5'd8, dsm_en=1 -> osc_code=101 on exactly 8 of every 32 cycles, else 100.
// - Saturation: applied_code=8191, dsm_en=1 -> osc_code stays 255; dsm_en=0 -> 255 (round, clamped).
// - Retarget/enable: new valid mid-SLEW reverses direction next cycle; fftl_en=0 for 10 cycles -> all outputs frozen.

Source files
------------

// File: rtl/fine_track_pkg.sv
// Shared constants and state type for the fine-tracking control path.
package fine_track_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned FRAC_W = 5;
    localparam int unsigned STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        HOLD
    } fcd_state_t;

endpackage

// File: rtl/fcd_dsm1.sv
// First-order delta-sigma on the fractional code bits, with a saturating
// integer add so the oscillator bank code never wraps past full scale.
module fcd_dsm1 #(
    parameter int unsigned FRAC_W = 5,
    parameter int unsigned INT_W  = 8
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dsm_en,
    input  logic [INT_W-1:0]  int_part,
    input  logic [FRAC_W-1:0] frac_part,
    output logic [INT_W-1:0]  osc_code
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              inc;
    logic [INT_W:0]    raw;
    logic [INT_W-1:0]  osc_next;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, frac_part};
        // Dither off falls back to round-to-nearest on the fraction MSB.
        inc = dsm_en ? sum[FRAC_W] : frac_part[FRAC_W-1];
        raw = {1'b0, int_part} + {{INT_W{1'b0}}, inc};
        osc_next = raw[INT_W] ? '1 : raw[INT_W-1:0];
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            osc_code <= '0;
        end else if (en) begin
            acc      <= dsm_en ? sum[FRAC_W-1:0] : '0;
            osc_code <= osc_next;
        end
    end

endmodule

// File: rtl/fine_con_dsm_driver.sv
// Slews the applied fine-control code toward the tracker/manual target and
// drives the oscillator bank through a delta-sigma fraction dither.
module fine_con_dsm_driver
    import fine_track_pkg::*;
#(
    parameter int unsigned CODE_W = fine_track_pkg::CODE_W,
    parameter int unsigned FRAC_W = fine_track_pkg::FRAC_W,
    parameter int unsigned STEP_W = fine_track_pkg::STEP_W,
    localparam int unsigned INT_W = CODE_W - FRAC_W
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              fftl_en,
    input  logic [CODE_W-1:0] fine_con_in,
    input  logic              fine_con_valid,
    input  logic              manual_mode,
    input  logic [CODE_W-1:0] manual_control_osc,
    input  logic [STEP_W-1:0] slew_step,
    input  logic              dsm_en,
    output logic [INT_W-1:0]  osc_code,
    output logic [CODE_W-1:0] applied_code,
    output logic              settled
);

    fcd_state_t          state;
    logic [CODE_W-1:0]   target_q;
    logic [CODE_W-1:0]   target_d;
    logic signed [CODE_W:0] diff;
    logic [CODE_W:0]     diff_mag;
    logic [CODE_W:0]     step_ext;
    logic [CODE_W-1:0]   slew_next;

    always_comb begin
        target_d = target_q;
        if (manual_mode) begin
            target_d = manual_control_osc;
        end else if (fine_con_valid) begin
            target_d = fine_con_in;
        end

        // Step is taken toward the currently registered target; a target
        // loaded on the same edge only steers the following cycle.
        diff     = $signed({1'b0, target_q}) - $signed({1'b0, applied_code});
        diff_mag = diff[CODE_W] ? $unsigned(-diff) : $unsigned(diff);
        step_ext = (CODE_W+1)'(slew_step);
        if (slew_step == '0 || diff_mag <= step_ext) begin
            slew_next = target_q;
        end else if (diff[CODE_W]) begin
            slew_next = applied_code - CODE_W'(slew_step);
        end else begin
            slew_next = applied_code + CODE_W'(slew_step);
        end
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            target_q     <= '0;
            applied_code <= '0;
            settled      <= 1'b0;
        end else if (fftl_en) begin
            target_q <= target_d;
            case (state)
                IDLE: begin
                    state   <= SLEW;
                    settled <= 1'b0;
                end
                SLEW: begin
                    applied_code <= slew_next;
                    settled      <= 1'b0;
                    // Compare against the incoming target so a coincident
                    // retarget never parks HOLD away from the real target.
                    if (slew_next == target_d) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (target_d != target_q) begin
                        state   <= SLEW;
                        settled <= 1'b0;
                    end else begin
                        settled <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    settled <= 1'b0;
                end
            endcase
        end
    end

    fcd_dsm1 #(
        .FRAC_W(FRAC_W),
        .INT_W (INT_W)
    ) u_dsm (
        .ref_clk  (ref_clk),
        .rst      (rst),
        .en       (fftl_en),
        .dsm_en   (dsm_en),
        .int_part (applied_code[CODE_W-1:FRAC_W]),
        .frac_part(applied_code[FRAC_W-1:0]),
        .osc_code (osc_code)
    );

endmodule

// File: tb/tb_fine_con_dsm_driver.sv
// Directed and randomized checks of fine_con_dsm_driver against an
// arithmetic reference model of target tracking, slewing and dither.
module tb_fine_con_dsm_driver;

    localparam int CW = 13;
    localparam int SW = 4;
    localparam int IW = 8;

    logic          ref_clk;
    logic          rst;
    logic          fftl_en;
    logic [CW-1:0] fine_con_in;
    logic          fine_con_valid;
    logic          manual_mode;
    logic [CW-1:0] manual_control_osc;
    logic [SW-1:0] slew_step;
    logic          dsm_en;
    logic [IW-1:0] osc_code;
    logic [CW-1:0] applied_code;
    logic          settled;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = not started, 1 = moving, 2 = resting.
    int m_target, m_applied, m_acc, m_osc, m_settled, m_phase;

    fine_con_dsm_driver #(
        .CODE_W(13),
        .FRAC_W(5),
        .STEP_W(4)
    ) dut (
        .ref_clk           (ref_clk),
        .rst               (rst),
        .fftl_en           (fftl_en),
        .fine_con_in       (fine_con_in),
        .fine_con_valid    (fine_con_valid),
        .manual_mode       (manual_mode),
        .manual_control_osc(manual_control_osc),
        .slew_step         (slew_step),
        .dsm_en            (dsm_en),
        .osc_code          (osc_code),
        .applied_code      (applied_code),
        .settled           (settled)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_target = 0; m_applied = 0; m_acc = 0;
        m_osc = 0; m_settled = 0; m_phase = 0;
    endtask

    task automatic model_tick();
        int t_next, intp, frac, bump, d, mag, st;
        if (!fftl_en) return;
        t_next = manual_mode ? int'(manual_control_osc)
               : (fine_con_valid ? int'(fine_con_in) : m_target);
        intp = m_applied / 32;
        frac = m_applied % 32;
        if (dsm_en) begin
            bump  = (m_acc + frac) / 32;
            m_acc = (m_acc + frac) % 32;
        end else begin
            bump  = (frac >= 16) ? 1 : 0;
            m_acc = 0;
        end
        m_osc = (intp + bump > 255) ? 255 : intp + bump;
        st = int'(slew_step);
        if (m_phase == 0) begin
            m_phase = 1;
            m_settled = 0;
        end else if (m_phase == 1) begin
            d   = m_target - m_applied;
            mag = (d < 0) ? -d : d;
            if (st == 0 || mag <= st) m_applied = m_target;
            else if (d < 0) m_applied = m_applied - st;
            else m_applied = m_applied + st;
            m_settled = 0;
            if (m_applied == t_next) m_phase = 2;
        end else begin
            if (t_next != m_target) begin
                m_phase = 1;
                m_settled = 0;
            end else begin
                m_settled = 1;
            end
        end
        m_target = t_next;
    endtask

    task automatic tick();
        @(posedge ref_clk);
        model_tick();
        #1;
        check("applied", int'(applied_code), m_applied);
        check("osc", int'(osc_code), m_osc);
        check("settled", int'(settled), m_settled);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_target(input int val);
        fine_con_in = CW'(val);
        fine_con_valid = 1'b1;
        tick();
        fine_con_valid = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check({tag, "_applied"}, int'(applied_code), 0);
        check({tag, "_osc"}, int'(osc_code), 0);
        check({tag, "_settled"}, int'(settled), 0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int prev, moves, maxv, cnt_hi, cnt_lo, cnt_sat, changes;
        rst = 1'b0;
        fftl_en = 1'b1;
        fine_con_in = '0;
        fine_con_valid = 1'b0;
        manual_mode = 1'b0;
        manual_control_osc = '0;
        slew_step = '0;
        dsm_en = 1'b1;
        model_reset();
        #12;
        check("reset_applied", int'(applied_code), 0);
        check("reset_osc", int'(osc_code), 0);
        check("reset_settled", int'(settled), 0);
        rst = 1'b1;
        ticks(4);
        check("post_reset_no_move", int'(applied_code), 0);

        // Slew 0 -> 1000 at 15 per cycle
        slew_step = 4'd15;
        send_target(1000);
        moves = 0; maxv = 0;
        for (int i = 0; i < 100 && settled !== 1'b1; i++) begin
            prev = int'(applied_code);
            tick();
            if (int'(applied_code) != prev) moves++;
            if (int'(applied_code) > maxv) maxv = int'(applied_code);
        end
        check("slew_moves", moves, 67);
        check("slew_final", int'(applied_code), 1000);
        check("slew_max", maxv, 1000);
        check("slew_settled", int'(settled), 1);

        // Immediate jump with slew_step = 0
        slew_step = 4'd0;
        send_target(4000);
        check("jump_lat1", int'(applied_code), 1000);
        tick();
        check("jump_at2", int'(applied_code), 4000);
        check("jump_not_yet", int'(settled), 0);
        tick();
        check("jump_settled", int'(settled), 1);

        // Dither: 100 + 8/32
        send_target(100 * 32 + 8);
        ticks(4);
        cnt_hi = 0; cnt_lo = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (osc_code == 8'd101) cnt_hi++;
            if (osc_code == 8'd100) cnt_lo++;
        end
        check("dither_hi", cnt_hi, 8);
        check("dither_lo", cnt_lo, 24);

        // Saturation at full scale
        send_target(8191);
        ticks(4);
        cnt_sat = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (osc_code == 8'd255) cnt_sat++;
        end
        check("sat_dsm", cnt_sat, 32);
        dsm_en = 1'b0;
        ticks(2);
        check("sat_round", int'(osc_code), 255);
        dsm_en = 1'b1;

        // Retarget mid-slew reverses direction
        slew_step = 4'd4;
        send_target(0);
        ticks(10);
        prev = int'(applied_code);
        send_target(8191);
        check("retgt_old_dir", int'(applied_code), prev - 4);
        tick();
        check("retgt_new_dir", int'(applied_code), prev);

        // Freeze with fftl_en = 0, including an ignored strobe
        send_target(10);
        tick();
        fftl_en = 1'b0;
        changes = 0;
        prev = int'(applied_code);
        for (int i = 0; i < 10; i++) begin
            fine_con_valid = (i == 3);
            fine_con_in = 13'd5000;
            tick();
            if (int'(applied_code) != prev) changes++;
        end
        fine_con_valid = 1'b0;
        check("freeze_changes", changes, 0);
        fftl_en = 1'b1;
        ticks(3);

        // Asynchronous reset while still slewing
        async_reset_check("rst_mid_slew");
        ticks(5);
        check("rst_release_hold", int'(applied_code), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            fftl_en = ($urandom_range(0, 9) != 0);
            fine_con_valid = ($urandom_range(0, 7) == 0);
            fine_con_in = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(8150, 8191))
                                                      : CW'($urandom);
            if ($urandom_range(0, 63) == 0) manual_mode = ~manual_mode;
            if ($urandom_range(0, 15) == 0) manual_control_osc = CW'($urandom);
            if ($urandom_range(0, 31) == 0) slew_step = SW'($urandom);
            if ($urandom_range(0, 63) == 0) dsm_en = ~dsm_en;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
